pipe_stage_buffer: RTL and testbench
====================================

PIPE_STAGE_BUFFER -- requirements
Module: pipe_stage_buffer

Interface
REQ-001 Parameter DATA_W, default 64: payload width (pc, instruction, operands, results).
REQ-002 Parameter CTRL_W, default 16: control-bit width (register write, memory write/read, branch, stack controls).
REQ-003 Parameter SKID, default 1: 1 selects a two-entry skid buffer with registered in_ready; 0 selects a single register with combinational in_ready.
REQ-004 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-high reset.
REQ-006 Port in_valid, input, 1: upstream beat present.
REQ-007 Port in_ready, output, 1: buffer accepts a beat this cycle.
REQ-008 Port in_ctrl, input, CTRL_W: upstream control bits.
REQ-009 Port in_data, input, DATA_W: upstream payload.
REQ-010 Port out_valid, output, 1: downstream beat present.
REQ-011 Port out_ready, input, 1: downstream consumes the beat this cycle.
REQ-012 Port out_ctrl, output, CTRL_W: control bits of the head entry; all-zero when out_valid=0.
REQ-013 Port out_data, output, DATA_W: payload of the head entry.
REQ-014 Port flush, input, 1: synchronous kill of all held entries.
REQ-015 Port occupancy, output, 2: entries held (0..2).
REQ-016 Port stall_count, output, 16: saturating count of downstream stall cycles.

Function
REQ-017 Accept occurs when in_valid=1 and in_ready=1; emit occurs when out_valid=1 and out_ready=1; both are evaluated on the same edge.
REQ-018 Latency from accept to out_valid=1 SHALL be exactly one cycle; beats SHALL leave in acceptance order, with none duplicated or lost except by flush.
REQ-019 State machine for SKID=1: EMPTY, ONE, TWO; occupancy SHALL equal 0, 1, 2 respectively.
REQ-020 In EMPTY, accept moves the beat to the main entry and the state to ONE.
REQ-021 In ONE, emit without accept goes to EMPTY; accept without emit writes the skid entry and goes to TWO; accept with emit replaces the main entry and stays in ONE.
REQ-022 In TWO, in_ready SHALL be 0; emit copies skid to main and goes to ONE.
REQ-023 For SKID=1, in_ready SHALL be a register output equal to 1 in EMPTY and ONE and 0 in TWO.
REQ-024 For SKID=0, only EMPTY and ONE exist; in_ready SHALL be (!out_valid || out_ready), combinational.
REQ-025 out_ctrl SHALL be forced to zero whenever out_valid=0, so an empty stage presents a NOP bubble; out_data SHALL retain its last value when out_valid=0.
REQ-026 flush SHALL take priority over accept and emit on the same edge: the next state is EMPTY, any beat offered that cycle is dropped, and in_ready is 1 the following cycle.
REQ-027 stall_count SHALL increment on each cycle with out_valid=1 and out_ready=0, saturate at 0xFFFF, and be unaffected by flush.
REQ-028 Input changes while in_ready=0 SHALL have no effect on state.

Reset
REQ-029 Asserting reset SHALL immediately drive state EMPTY, out_valid=0, out_ctrl=0, out_data=0, occupancy=0, and stall_count=0, and clear the skid entry to 0.
REQ-030 During and after reset, in_ready SHALL be 1 for both SKID settings.
REQ-031 Reset asserted mid-transfer SHALL discard all held beats; the first post-reset accept behaves as from EMPTY.

Structure
REQ-032 Package pipe_pkg SHALL hold the state enumeration (EMPTY, ONE, TWO) and the constant STALL_CNT_W=16.
REQ-033 Sub-module pipe_sat_counter (width-parametrised saturating counter) SHALL implement stall_count; the datapath stays in the top module.

Verification
REQ-034 SKID=1: accept 0xA1, 0xA2, 0xA3 back-to-back with out_ready=1 -> out_data shows A1, A2, A3 on consecutive cycles, each one cycle after acceptance; occupancy stays 1.
REQ-035 SKID=1: out_ready=0, offer 0xB1 then 0xB2 -> occupancy=2, in_ready=0, out_data=B1; raise out_ready -> B1, then B2 emitted, and stall_count equals the stall cycles.
REQ-036 SKID=1: flush in TWO with in_valid=1 carrying 0xC3 -> next cycle occupancy=0, out_valid=0, out_ctrl=0, in_ready=1, and 0xC3 never appears.
REQ-037 SKID=0: hold out_ready=0 for 70000 cycles with out_valid=1 -> stall_count=0xFFFF, in_ready=0; out_ready=1 -> in_ready=1 in the same cycle.
REQ-038 Assert reset asynchronously mid-cycle while occupancy=2 -> outputs clear before the next edge; beat 0xD1 after deassertion emerges after one cycle.
REQ-039 Random valid/ready traffic with a scoreboard, both SKID settings, CTRL_W=8, DATA_W=40 -> order preserved, no loss, and out_ctrl=0 whenever out_valid=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline stage buffer.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_e;

  localparam int STALL_CNT_W = 16;

  // State encoding doubles as the entry count.
  function automatic logic [1:0] state_occupancy(input pipe_state_e s);
    return 2'(s);
  endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter: increments on inc_i, sticks at all-ones, visible one cycle later.
// No backpressure; async active-high reset clears it.
module pipe_sat_counter
  import pipe_pkg::*;
#(
  parameter int W = STALL_CNT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/pipe_stage_buffer.sv
// Pipeline stage register: one-cycle accept-to-valid latency, in-order, flushable.
// SKID=1 gives a two-entry skid with registered in_ready; SKID=0 a single entry with combinational in_ready.
module pipe_stage_buffer
  import pipe_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 16,
  parameter int SKID   = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [CTRL_W-1:0]      in_ctrl,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CTRL_W-1:0]      out_ctrl,
  output logic [DATA_W-1:0]      out_data,
  input  logic                   flush,
  output logic [1:0]             occupancy,
  output logic [STALL_CNT_W-1:0] stall_count
);

  pipe_state_e       state_q;
  logic [CTRL_W-1:0] main_ctrl_q;
  logic [DATA_W-1:0] main_data_q;
  logic [CTRL_W-1:0] skid_ctrl_q;
  logic [DATA_W-1:0] skid_data_q;
  logic              rdy_q;
  logic              accept;
  logic              emit;

  assign out_valid = (state_q != EMPTY);
  assign in_ready  = (SKID != 0) ? rdy_q : (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign emit      = out_valid && out_ready;

  // Empty stage presents an all-zero control word so downstream sees a bubble.
  assign out_ctrl  = out_valid ? main_ctrl_q : '0;
  assign out_data  = main_data_q;
  assign occupancy = state_occupancy(state_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= EMPTY;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
      rdy_q       <= 1'b1;
    end else if (flush) begin
      state_q <= EMPTY;
      rdy_q   <= 1'b1;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            main_ctrl_q <= in_ctrl;
            main_data_q <= in_data;
            state_q     <= ONE;
          end
        end
        ONE: begin
          case ({accept, emit})
            2'b01: state_q <= EMPTY;
            2'b10: begin
              if (SKID != 0) begin
                skid_ctrl_q <= in_ctrl;
                skid_data_q <= in_data;
                state_q     <= TWO;
                rdy_q       <= 1'b0;
              end
            end
            2'b11: begin
              main_ctrl_q <= in_ctrl;
              main_data_q <= in_data;
            end
            default: ;
          endcase
        end
        TWO: begin
          if (emit) begin
            main_ctrl_q <= skid_ctrl_q;
            main_data_q <= skid_data_q;
            state_q     <= ONE;
            rdy_q       <= 1'b1;
          end
        end
        default: begin
          state_q <= EMPTY;
          rdy_q   <= 1'b1;
        end
      endcase
    end
  end

  pipe_sat_counter #(
    .W(STALL_CNT_W)
  ) u_stall_cnt (
    .clk    (clk),
    .reset  (reset),
    .inc_i  (out_valid && !out_ready),
    .count_o(stall_count)
  );

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Directed and scoreboarded checks of pipe_stage_buffer in skid and single-entry modes.
module tb_pipe_stage_buffer;

  localparam int CW = 8;
  localparam int DW = 40;

  logic          clk;
  logic          rst1, rst0;
  logic          iv1, ir1, ov1, ordy1, fl1;
  logic [CW-1:0] ic1, oc1;
  logic [DW-1:0] id1, od1;
  logic [1:0]    occ1;
  logic [15:0]   sc1;
  logic          iv0, ir0, ov0, ordy0, fl0;
  logic [CW-1:0] ic0, oc0;
  logic [DW-1:0] id0, od0;
  logic [1:0]    occ0;
  logic [15:0]   sc0;

  int checks = 0;
  int errors = 0;

  logic [CW+DW-1:0] q1[$];
  logic [CW+DW-1:0] q0[$];

  pipe_stage_buffer #(.DATA_W(DW), .CTRL_W(CW), .SKID(1)) u_dut1 (
    .clk(clk), .reset(rst1), .in_valid(iv1), .in_ready(ir1), .in_ctrl(ic1), .in_data(id1),
    .out_valid(ov1), .out_ready(ordy1), .out_ctrl(oc1), .out_data(od1), .flush(fl1),
    .occupancy(occ1), .stall_count(sc1)
  );

  pipe_stage_buffer #(.DATA_W(DW), .CTRL_W(CW), .SKID(0)) u_dut0 (
    .clk(clk), .reset(rst0), .in_valid(iv0), .in_ready(ir0), .in_ctrl(ic0), .in_data(id0),
    .out_valid(ov0), .out_ready(ordy0), .out_ctrl(oc0), .out_data(od0), .flush(fl0),
    .occupancy(occ0), .stall_count(sc0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One cycle of random traffic on both instances, checked against the queues at the falling edge.
  task automatic rnd_cycle(input bit drive);
    logic [63:0]      r;
    logic [CW+DW-1:0] exp;
    @(posedge clk);
    #1;
    if (drive) begin
      r = {$urandom, $urandom};
      iv1 = ($urandom_range(0, 3) != 0); ic1 = r[47:40]; id1 = r[39:0];
      ordy1 = ($urandom_range(0, 2) != 0);
      r = {$urandom, $urandom};
      iv0 = ($urandom_range(0, 3) != 0); ic0 = r[47:40]; id0 = r[39:0];
      ordy0 = ($urandom_range(0, 2) != 0);
    end else begin
      iv1 = 1'b0; ordy1 = 1'b1;
      iv0 = 1'b0; ordy0 = 1'b1;
    end
    #4;
    chk("rnd1_occ", 64'(occ1), 64'(q1.size()));
    chk("rnd1_rdy", 64'(ir1), 64'(q1.size() < 2));
    if (!ov1) chk("rnd1_nop", 64'(oc1), 64'h0);
    if (ov1 && ordy1) begin
      if (q1.size() == 0) chk("rnd1_extra", 64'h1, 64'h0);
      else begin
        exp = q1.pop_front();
        chk("rnd1_beat", 64'({oc1, od1}), 64'(exp));
      end
    end
    if (iv1 && ir1) q1.push_back({ic1, id1});
    chk("rnd0_occ", 64'(occ0), 64'(q0.size()));
    chk("rnd0_rdy", 64'(ir0), 64'((q0.size() == 0) || ordy0));
    if (!ov0) chk("rnd0_nop", 64'(oc0), 64'h0);
    if (ov0 && ordy0) begin
      if (q0.size() == 0) chk("rnd0_extra", 64'h1, 64'h0);
      else begin
        exp = q0.pop_front();
        chk("rnd0_beat", 64'({oc0, od0}), 64'(exp));
      end
    end
    if (iv0 && ir0) q0.push_back({ic0, id0});
  endtask

  initial begin
    rst1 = 1'b1; rst0 = 1'b1;
    iv1 = 0; ic1 = '0; id1 = '0; ordy1 = 0; fl1 = 0;
    iv0 = 0; ic0 = '0; id0 = '0; ordy0 = 0; fl0 = 0;
    #3;
    chk("rst_ir1", 64'(ir1), 64'h1);
    chk("rst_ir0", 64'(ir0), 64'h1);
    chk("rst_ov1", 64'(ov1), 64'h0);
    chk("rst_occ1", 64'(occ1), 64'h0);
    chk("rst_oc1", 64'(oc1), 64'h0);
    chk("rst_od1", 64'(od1), 64'h0);
    chk("rst_sc1", 64'(sc1), 64'h0);
    chk("rst_occ0", 64'(occ0), 64'h0);
    @(negedge clk);
    rst1 = 1'b0; rst0 = 1'b0;
    ordy0 = 1'b1;
    tick;

    // Back-to-back streaming through the skid stage
    ordy1 = 1; iv1 = 1; id1 = 40'hA1; ic1 = 8'h11;
    tick;
    chk("s1_a1_dat", 64'(od1), 64'hA1); chk("s1_a1_ctl", 64'(oc1), 64'h11);
    chk("s1_a1_occ", 64'(occ1), 64'h1); chk("s1_a1_rdy", 64'(ir1), 64'h1);
    id1 = 40'hA2; ic1 = 8'h12;
    tick;
    chk("s1_a2_dat", 64'(od1), 64'hA2); chk("s1_a2_occ", 64'(occ1), 64'h1);
    id1 = 40'hA3; ic1 = 8'h13;
    tick;
    chk("s1_a3_dat", 64'(od1), 64'hA3); chk("s1_a3_occ", 64'(occ1), 64'h1);
    iv1 = 0;
    tick;
    chk("s1_drain_ov", 64'(ov1), 64'h0); chk("s1_drain_oc", 64'(oc1), 64'h0);
    chk("s1_drain_od", 64'(od1), 64'hA3); chk("s1_drain_occ", 64'(occ1), 64'h0);

    // Fill both entries under stall, then release
    ordy1 = 0; iv1 = 1; id1 = 40'hB1; ic1 = 8'h21;
    tick;
    chk("b_one_occ", 64'(occ1), 64'h1); chk("b_one_rdy", 64'(ir1), 64'h1);
    id1 = 40'hB2; ic1 = 8'h22;
    tick;
    chk("b_two_occ", 64'(occ1), 64'h2); chk("b_two_rdy", 64'(ir1), 64'h0);
    chk("b_two_dat", 64'(od1), 64'hB1); chk("b_two_sc", 64'(sc1), 64'h1);
    id1 = 40'hB9; ic1 = 8'h29;
    tick;
    chk("b_hold_occ", 64'(occ1), 64'h2); chk("b_hold_dat", 64'(od1), 64'hB1);
    chk("b_hold_sc", 64'(sc1), 64'h2);
    ordy1 = 1; iv1 = 0;
    tick;
    chk("b_pop1_dat", 64'(od1), 64'hB2); chk("b_pop1_ctl", 64'(oc1), 64'h22);
    chk("b_pop1_occ", 64'(occ1), 64'h1); chk("b_pop1_rdy", 64'(ir1), 64'h1);
    tick;
    chk("b_pop2_ov", 64'(ov1), 64'h0); chk("b_pop2_sc", 64'(sc1), 64'h2);

    // Flush in TWO with a beat offered
    ordy1 = 0; iv1 = 1; id1 = 40'hC1; ic1 = 8'h31;
    tick;
    id1 = 40'hC2; ic1 = 8'h32;
    tick;
    chk("c_two_occ", 64'(occ1), 64'h2);
    fl1 = 1; id1 = 40'hC3; ic1 = 8'h33;
    tick;
    chk("c_fl_occ", 64'(occ1), 64'h0); chk("c_fl_ov", 64'(ov1), 64'h0);
    chk("c_fl_oc", 64'(oc1), 64'h0); chk("c_fl_rdy", 64'(ir1), 64'h1);
    chk("c_fl_sc", 64'(sc1), 64'h4);
    fl1 = 0; iv1 = 0; ordy1 = 1;
    tick;
    chk("c_post_ov", 64'(ov1), 64'h0); chk("c_post_od", 64'(od1), 64'hC1);
    // Flush wins over a simultaneous accept and emit in ONE
    iv1 = 1; id1 = 40'hC4; ic1 = 8'h34;
    tick;
    chk("c_one_dat", 64'(od1), 64'hC4);
    fl1 = 1; id1 = 40'hC5; ic1 = 8'h35;
    tick;
    chk("c_fl1_occ", 64'(occ1), 64'h0); chk("c_fl1_ov", 64'(ov1), 64'h0);
    fl1 = 0; iv1 = 0;
    tick;
    chk("c_fl1_post", 64'(ov1), 64'h0);

    // Asynchronous reset while full
    ordy1 = 0; iv1 = 1; id1 = 40'hE1; ic1 = 8'h41;
    tick;
    id1 = 40'hE2; ic1 = 8'h42;
    tick;
    iv1 = 0;
    chk("r_full_occ", 64'(occ1), 64'h2);
    #2 rst1 = 1'b1;
    #1;
    chk("r_occ", 64'(occ1), 64'h0); chk("r_ov", 64'(ov1), 64'h0);
    chk("r_oc", 64'(oc1), 64'h0); chk("r_od", 64'(od1), 64'h0);
    chk("r_sc", 64'(sc1), 64'h0); chk("r_rdy", 64'(ir1), 64'h1);
    #2 rst1 = 1'b0;
    iv1 = 1; id1 = 40'hD1; ic1 = 8'h51; ordy1 = 1;
    tick;
    chk("r_d1_ov", 64'(ov1), 64'h1); chk("r_d1_dat", 64'(od1), 64'hD1);
    chk("r_d1_occ", 64'(occ1), 64'h1);
    iv1 = 0;
    tick;
    chk("r_d1_gone", 64'(ov1), 64'h0);

    // Long stall saturates the counter on the single-entry stage
    ordy0 = 0; iv0 = 1; id0 = 40'h5A; ic0 = 8'h5A;
    tick;
    chk("p_ov0", 64'(ov0), 64'h1); chk("p_rdy0", 64'(ir0), 64'h0);
    chk("p_sc0", 64'(sc0), 64'h0);
    id0 = 40'h5B; ic0 = 8'h5B;
    repeat (1000) @(posedge clk);
    #1;
    chk("p_sc0_1000", 64'(sc0), 64'd1000);
    repeat (69000) @(posedge clk);
    #1;
    chk("p_sc0_sat", 64'(sc0), 64'hFFFF); chk("p_sat_rdy0", 64'(ir0), 64'h0);
    chk("p_sat_dat0", 64'(od0), 64'h5A);
    ordy0 = 1;
    #1;
    chk("p_comb_rdy0", 64'(ir0), 64'h1);
    tick;
    chk("p_pass_dat0", 64'(od0), 64'h5B); chk("p_pass_ov0", 64'(ov0), 64'h1);
    chk("p_pass_sc0", 64'(sc0), 64'hFFFF);
    iv0 = 0;
    tick;
    chk("p_empty_ov0", 64'(ov0), 64'h0); chk("p_empty_oc0", 64'(oc0), 64'h0);

    // Random traffic on both instances
    repeat (1500) rnd_cycle(1'b1);
    repeat (4) rnd_cycle(1'b0);
    chk("rnd1_left", 64'(q1.size()), 64'h0);
    chk("rnd0_left", 64'(q0.size()), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
